// File: rtl/crate_register_bridge.sv
// Wishbone window -> NUM_CH TURFIO register spaces over an Aurora UFC command/response stream.
// Failures terminate with 0xFFFFFFFF data; define CRATE_BRIDGE_ERR_EN to signal them on err_o instead of ack_o.
module crate_register_bridge #(
  parameter int NUM_CH        = 4,
  parameter int CH_ADR_W      = 25,
  parameter int ADR_W         = 27,
  parameter int TIMEOUT_VALUE = 2500000,
  localparam int SEL_W        = $clog2(NUM_CH)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [2*NUM_CH-1:0]   bridge_type_i,
  input  logic [4*NUM_CH-1:0]   bridge_valid_i,
  input  logic                  bridge_cyc_i,
  input  logic                  bridge_stb_i,
  input  logic                  bridge_we_i,
  input  logic [ADR_W-1:0]      bridge_adr_i,
  input  logic [31:0]           bridge_dat_i,
  input  logic [3:0]            bridge_sel_i,
  output logic [31:0]           bridge_dat_o,
  output logic                  bridge_ack_o,
  output logic                  bridge_err_o,
  output logic                  bridge_rty_o,
  output logic [31:0]           m_cmd_tdata,
  output logic                  m_cmd_tvalid,
  output logic                  m_cmd_tlast,
  output logic [SEL_W-1:0]      m_cmd_tdest,
  input  logic                  m_cmd_tready,
  input  logic [31:0]           s_resp_tdata,
  input  logic                  s_resp_tvalid,
  input  logic [SEL_W-1:0]      s_resp_tuser,
  output logic                  s_resp_tready,
  output logic [NUM_CH-1:0]     timeout_o,
  output logic [NUM_CH-1:0]     invalid_o,
  output logic [NUM_CH-1:0]     stale_o
);

  localparam int CNT_W = $clog2(TIMEOUT_VALUE + 1);

  if (ADR_W != CH_ADR_W + SEL_W) begin : g_bad_adr_w
    $error("crate_register_bridge: ADR_W must equal CH_ADR_W + SEL_W");
  end

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*NUM_CH-1:0] type_reg;
  logic [SEL_W-1:0]    ch_q;
  logic                we_q;
  logic                fail_q;

  logic [1:0] type_arr  [NUM_CH];
  logic [3:0] valid_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign type_arr[g]  = type_reg[2*g +: 2];
    assign valid_arr[g] = bridge_valid_i[4*g +: 4];
  end

  logic             req;
  logic [SEL_W-1:0] req_ch;
  logic [1:0]       req_type;
  logic             req_ok;
  logic             busy;
  logic             tmo_hit;
  logic             resp_hit;

  assign req      = bridge_cyc_i & bridge_stb_i;
  assign req_ch   = bridge_adr_i[ADR_W-1:CH_ADR_W];
  assign req_type = type_arr[req_ch];
  assign req_ok   = valid_arr[req_ch][req_type] && (req_type == 2'b01) &&
                    !(bridge_we_i && (bridge_sel_i != 4'hF));
  assign busy     = (state_q == ADDR) || (state_q == DATA) || (state_q == RESP);
  // Timeout outranks any handshake landing in the same cycle.
  assign tmo_hit  = busy && (cnt_q == CNT_W'(TIMEOUT_VALUE));
  assign resp_hit = (state_q == RESP) && s_resp_tvalid && (s_resp_tuser == ch_q) && !tmo_hit;

  always_comb begin
    state_d      = state_q;
    m_cmd_tvalid = 1'b0;
    m_cmd_tdata  = '0;
    m_cmd_tlast  = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = req_ok ? ADDR : DONE;
      ADDR: begin
        if (tmo_hit) begin
          state_d = DONE;
        end else begin
          m_cmd_tvalid = 1'b1;
          m_cmd_tdata  = {~we_q, {(31-CH_ADR_W){1'b0}}, bridge_adr_i[CH_ADR_W-1:2], 2'b00};
          m_cmd_tlast  = ~we_q;
          if (m_cmd_tready) state_d = we_q ? DATA : RESP;
        end
      end
      DATA: begin
        if (tmo_hit) begin
          state_d = DONE;
        end else begin
          m_cmd_tvalid = 1'b1;
          m_cmd_tdata  = bridge_dat_i;
          m_cmd_tlast  = 1'b1;
          if (m_cmd_tready) state_d = DONE;
        end
      end
      RESP: if (tmo_hit || resp_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_cmd_tdest   = ch_q;
  assign s_resp_tready = 1'b1;
  assign bridge_rty_o  = 1'b0;

`ifdef CRATE_BRIDGE_ERR_EN
  assign bridge_ack_o = (state_q == DONE) && !fail_q;
  assign bridge_err_o = (state_q == DONE) && fail_q;
`else
  assign bridge_ack_o = (state_q == DONE);
  assign bridge_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      type_reg     <= '0;
      ch_q         <= '0;
      we_q         <= 1'b0;
      fail_q       <= 1'b0;
      bridge_dat_o <= '0;
      timeout_o    <= '0;
      invalid_o    <= '0;
      stale_o      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= busy ? cnt_q + CNT_W'(1) : '0;

      // Type map is frozen for the whole transaction once a request is seen.
      if (state_q == IDLE && !req) type_reg <= bridge_type_i;
      if (state_q == IDLE && req) begin
        ch_q   <= req_ch;
        we_q   <= bridge_we_i;
        fail_q <= ~req_ok;
      end
      if (tmo_hit) fail_q <= 1'b1;

      if ((state_q == IDLE && req && !req_ok) || tmo_hit) bridge_dat_o <= 32'hFFFF_FFFF;
      else if (resp_hit)                                 bridge_dat_o <= s_resp_tdata;

      invalid_o <= '0;
      if (state_q == IDLE && req && !req_ok) invalid_o[req_ch] <= 1'b1;
      timeout_o <= '0;
      if (tmo_hit) timeout_o[ch_q] <= 1'b1;
      stale_o <= '0;
      if (s_resp_tvalid && !resp_hit) stale_o[s_resp_tuser] <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, bridge_adr_i[1:0]};

endmodule

// File: tb/tb_crate_register_bridge.sv
// Directed bench for crate_register_bridge: reads, writes, rejects, timeout, stale flushing, mid-op reset.
`timescale 1ns/1ps
module tb_crate_register_bridge;
  localparam int NUM_CH = 4, CH_ADR_W = 25, ADR_W = 27, TMO = 40;
`ifdef CRATE_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  bridge_type_i;
  logic [15:0] bridge_valid_i;
  logic        bridge_cyc_i, bridge_stb_i, bridge_we_i;
  logic [26:0] bridge_adr_i;
  logic [31:0] bridge_dat_i;
  logic [3:0]  bridge_sel_i;
  logic [31:0] bridge_dat_o;
  logic        bridge_ack_o, bridge_err_o, bridge_rty_o;
  logic [31:0] m_cmd_tdata;
  logic        m_cmd_tvalid, m_cmd_tlast, m_cmd_tready;
  logic [1:0]  m_cmd_tdest;
  logic [31:0] s_resp_tdata;
  logic        s_resp_tvalid, s_resp_tready;
  logic [1:0]  s_resp_tuser;
  logic [3:0]  timeout_o, invalid_o, stale_o;

  always #5 wb_clk_i = ~wb_clk_i;

  crate_register_bridge #(
    .NUM_CH(NUM_CH), .CH_ADR_W(CH_ADR_W), .ADR_W(ADR_W), .TIMEOUT_VALUE(TMO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .bridge_type_i(bridge_type_i), .bridge_valid_i(bridge_valid_i),
    .bridge_cyc_i(bridge_cyc_i), .bridge_stb_i(bridge_stb_i), .bridge_we_i(bridge_we_i),
    .bridge_adr_i(bridge_adr_i), .bridge_dat_i(bridge_dat_i), .bridge_sel_i(bridge_sel_i),
    .bridge_dat_o(bridge_dat_o), .bridge_ack_o(bridge_ack_o), .bridge_err_o(bridge_err_o),
    .bridge_rty_o(bridge_rty_o),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tlast(m_cmd_tlast),
    .m_cmd_tdest(m_cmd_tdest), .m_cmd_tready(m_cmd_tready),
    .s_resp_tdata(s_resp_tdata), .s_resp_tvalid(s_resp_tvalid), .s_resp_tuser(s_resp_tuser),
    .s_resp_tready(s_resp_tready),
    .timeout_o(timeout_o), .invalid_o(invalid_o), .stale_o(stale_o)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  dest;
  } beat_t;
  beat_t beats[$];

  always @(negedge wb_clk_i)
    if (m_cmd_tvalid && m_cmd_tready) beats.push_back({m_cmd_tdata, m_cmd_tlast, m_cmd_tdest});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] r_dat;
  logic        r_ack, r_err;
  int          r_cyc;
  logic [3:0]  r_inv, r_tmo, r_stl;

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Holds a classic WB request until ack/err, counting edges from the sampling edge.
  task automatic wb_access(input logic we, input logic [26:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    bit done = 1'b0;
    r_inv = '0; r_tmo = '0; r_stl = '0; r_cyc = 0;
    r_ack = 1'b0; r_err = 1'b0; r_dat = '0;
    bridge_cyc_i = 1'b1; bridge_stb_i = 1'b1; bridge_we_i = we;
    bridge_adr_i = adr; bridge_dat_i = dat; bridge_sel_i = sel;
    while (!done && r_cyc < TMO + 20) begin
      @(posedge wb_clk_i); #1;
      r_cyc++;
      r_inv |= invalid_o; r_tmo |= timeout_o; r_stl |= stale_o;
      if (bridge_ack_o || bridge_err_o) begin
        done  = 1'b1;
        r_ack = bridge_ack_o; r_err = bridge_err_o; r_dat = bridge_dat_o;
      end
    end
    bridge_cyc_i = 1'b0; bridge_stb_i = 1'b0; bridge_we_i = 1'b0;
    chk("wb_terminated", {31'd0, done}, 32'd1);
  endtask

  task automatic send_resp(input logic [1:0] user, input logic [31:0] d, input int base,
                           input int dly);
    int w = 0;
    while (beats.size() <= base && w < 100) begin
      @(posedge wb_clk_i); #1;
      w++;
    end
    repeat (dly) @(posedge wb_clk_i);
    #1;
    s_resp_tvalid = 1'b1; s_resp_tuser = user; s_resp_tdata = d;
    @(posedge wb_clk_i); #1;
    s_resp_tvalid = 1'b0;
  endtask

  initial begin
    int base;
    int w;
    logic term;
    wb_rst_i = 1'b1;
    bridge_type_i  = 8'h56;     // ch3..1 Aurora, ch0 TURFCTL
    bridge_valid_i = 16'h7777;
    bridge_cyc_i = 0; bridge_stb_i = 0; bridge_we_i = 0;
    bridge_adr_i = '0; bridge_dat_i = '0; bridge_sel_i = 4'hF;
    m_cmd_tready = 1'b1;
    s_resp_tvalid = 1'b0; s_resp_tuser = '0; s_resp_tdata = '0;
    idle(3);

    chk("rst_ack", {31'd0, bridge_ack_o}, 32'd0);
    chk("rst_err", {31'd0, bridge_err_o}, 32'd0);
    chk("rst_dat", bridge_dat_o, 32'd0);
    chk("rst_tvalid", {31'd0, m_cmd_tvalid}, 32'd0);
    chk("rst_pulses", {20'd0, timeout_o, invalid_o, stale_o}, 32'd0);
    chk("resp_tready", {31'd0, s_resp_tready}, 32'd1);
    wb_rst_i = 1'b0;
    idle(2);

    // Read ch2, response five cycles after the address beat
    base = beats.size();
    fork
      wb_access(1'b0, {2'd2, 25'h0001238}, 32'd0, 4'hF);
      send_resp(2'd2, 32'hDEADBEEF, base, 5);
    join
    chk("rd_ack", {31'd0, r_ack}, 32'd1);
    chk("rd_err", {31'd0, r_err}, 32'd0);
    chk("rd_dat", r_dat, 32'hDEADBEEF);
    chk("rd_cycles", r_cyc, 32'd8);
    chk("rd_nbeats", beats.size() - base, 32'd1);
    chk("rd_addr", beats[base].d, 32'h80001238);
    chk("rd_last", {31'd0, beats[base].l}, 32'd1);
    chk("rd_dest", {30'd0, beats[base].dest}, 32'd2);
    idle(2);

    // Write ch1 with command path stalled for three cycles
    base = beats.size();
    fork
      wb_access(1'b1, {2'd1, 25'h0000104}, 32'h12345678, 4'hF);
      begin
        m_cmd_tready = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 m_cmd_tready = 1'b1;
      end
    join
    chk("wr_ack", {31'd0, r_ack}, 32'd1);
    chk("wr_cycles", r_cyc, 32'd5);
    chk("wr_nbeats", beats.size() - base, 32'd2);
    chk("wr_addr", beats[base].d, 32'h00000104);
    chk("wr_addr_last", {31'd0, beats[base].l}, 32'd0);
    chk("wr_data", beats[base+1].d, 32'h12345678);
    chk("wr_data_last", {31'd0, beats[base+1].l}, 32'd1);
    chk("wr_dest", {30'd0, beats[base+1].dest}, 32'd1);
    idle(2);

    // Partial byte-enable write rejected
    base = beats.size();
    wb_access(1'b1, {2'd1, 25'h0000008}, 32'h1, 4'h3);
    chk("sel_cycles", r_cyc, 32'd1);
    chk("sel_ack", {31'd0, r_ack}, {31'd0, !ERR_EN});
    chk("sel_err", {31'd0, r_err}, {31'd0, ERR_EN});
    chk("sel_dat", r_dat, 32'hFFFFFFFF);
    chk("sel_invalid", {28'd0, r_inv}, 32'h2);
    chk("sel_nbeats", beats.size() - base, 32'd0);
    idle(2);

    // TURFCTL channel answered as unimplemented
    wb_access(1'b0, {2'd0, 25'h0000010}, 32'd0, 4'hF);
    chk("type_cycles", r_cyc, 32'd1);
    chk("type_invalid", {28'd0, r_inv}, 32'h1);
    chk("type_nbeats", beats.size() - base, 32'd0);
    idle(2);

    // Aurora type not marked valid on ch1
    bridge_valid_i = 16'h7757;
    wb_access(1'b0, {2'd1, 25'h0000010}, 32'd0, 4'hF);
    chk("valid_invalid", {28'd0, r_inv}, 32'h2);
    chk("valid_dat", r_dat, 32'hFFFFFFFF);
    bridge_valid_i = 16'h7777;
    idle(2);

    // Read ch3 with no response
    wb_access(1'b0, {2'd3, 25'h0000020}, 32'd0, 4'hF);
    chk("tmo_cycles", r_cyc, TMO + 2);
    chk("tmo_pulse", {28'd0, r_tmo}, 32'h8);
    chk("tmo_dat", r_dat, 32'hFFFFFFFF);
    chk("tmo_ack", {31'd0, r_ack}, {31'd0, !ERR_EN});
    chk("tmo_err", {31'd0, r_err}, {31'd0, ERR_EN});
    chk("tmo_tvalid", {31'd0, m_cmd_tvalid}, 32'd0);
    idle(2);

    // Stale beat while idle
    s_resp_tvalid = 1'b1; s_resp_tuser = 2'd1; s_resp_tdata = 32'h5;
    idle(1);
    s_resp_tvalid = 1'b0;
    chk("stale_idle", {28'd0, stale_o}, 32'h2);
    idle(1);
    chk("stale_clear", {28'd0, stale_o}, 32'h0);

    // Wrong-channel beat during a ch3 read is flushed
    base = beats.size();
    fork
      wb_access(1'b0, {2'd3, 25'h0000040}, 32'd0, 4'hF);
      begin
        send_resp(2'd0, 32'hBAD0BAD0, base, 2);
        send_resp(2'd3, 32'hCAFE0003, base, 3);
      end
    join
    chk("stale_rd_pulse", {28'd0, r_stl}, 32'h1);
    chk("stale_rd_dat", r_dat, 32'hCAFE0003);
    chk("stale_rd_ack", {31'd0, r_ack}, 32'd1);
    idle(2);

    // Reset while waiting for a response
    base = beats.size();
    bridge_cyc_i = 1'b1; bridge_stb_i = 1'b1; bridge_we_i = 1'b0;
    bridge_adr_i = {2'd2, 25'h0000010};
    w = 0;
    while (beats.size() <= base && w < 20) begin
      idle(1);
      w++;
    end
    chk("rr_addr_sent", beats.size() - base, 32'd1);
    idle(2);
    wb_rst_i = 1'b1; bridge_cyc_i = 1'b0; bridge_stb_i = 1'b0;
    idle(1);
    wb_rst_i = 1'b0;
    chk("rr_tvalid", {31'd0, m_cmd_tvalid}, 32'd0);
    chk("rr_dat", bridge_dat_o, 32'd0);
    term = bridge_ack_o | bridge_err_o;
    repeat (6) begin
      idle(1);
      term |= bridge_ack_o | bridge_err_o;
    end
    chk("rr_no_term", {31'd0, term}, 32'd0);

    base = beats.size();
    fork
      wb_access(1'b0, {2'd2, 25'h0000030}, 32'd0, 4'hF);
      send_resp(2'd2, 32'h600DF00D, base, 1);
    join
    chk("rr_next_ack", {31'd0, r_ack}, 32'd1);
    chk("rr_next_dat", r_dat, 32'h600DF00D);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
